// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame width and baud timing helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } tx_state_t;

  localparam logic [3:0] start_data_stop_width = 4'd10;

  function automatic logic [23:0] calc_pulse_duration(input logic [23:0] baud_rate,
                                                      input logic [27:0] clock_freq);
    logic [27:0] w_q;
    w_q = clock_freq / {4'd0, baud_rate};
    return w_q[23:0];
  endfunction

  function automatic logic [23:0] calc_half_pulse_duration(input logic [23:0] baud_rate,
                                                           input logic [27:0] clock_freq);
    return calc_pulse_duration(baud_rate, clock_freq) >> 1;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: runs 0..pulse_duration-1 and flags the terminal count.
// Clear holds it at zero; at terminal count it wraps to zero on its own.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter logic [23:0] pulse_duration = 24'd25
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tc
);

  logic [23:0] r_count;

  assign o_tc = (r_count == pulse_duration - 24'd1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 24'd0;
    end else if (i_clear || o_tc) begin
      r_count <= 24'd0;
    end else begin
      r_count <= r_count + 24'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register so frames can run back to back.
// Line falls one cycle after accept when idle; uart_ready drops while the holding register is full.
module uart_tx
  import uart_pkg::*;
#(
  parameter logic [23:0] baud_rate  = 24'd4000000,
  parameter logic [27:0] clock_freq = 28'd100000000
) (
  input  logic       uart_clock,
  input  logic       uart_reset,
  input  logic [7:0] uart_d_in,
  input  logic       uart_start,
  output logic       uart_ready,
  output logic       uart_d_out,
  output logic       uart_busy,
  output logic       uart_done
);

  localparam logic [23:0] pulse_duration = calc_pulse_duration(baud_rate, clock_freq);

  tx_state_t  r_state;
  logic [7:0] r_hold;
  logic       r_ready;
  logic [7:0] r_shift;
  logic [2:0] r_idx;
  logic       r_line;
  logic       r_busy;
  logic       r_done;
  logic       w_tc;
  logic       w_clear;

  // The counter only runs while a frame is on the line, so every start bit begins at zero.
  assign w_clear = (r_state == IDLE);

  uart_baud_counter #(
    .pulse_duration(pulse_duration)
  ) u_baud (
    .i_clk   (uart_clock),
    .i_rst_n (uart_reset),
    .i_clear (w_clear),
    .o_tc    (w_tc)
  );

  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      r_state <= IDLE;
      r_hold  <= 8'd0;
      r_ready <= 1'b1;
      r_shift <= 8'd0;
      r_idx   <= 3'd0;
      r_line  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Accept and take never coincide: a take needs the holding register full, an accept needs it empty.
      if (uart_start && r_ready) begin
        r_hold  <= uart_d_in;
        r_ready <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_line <= 1'b1;
          if (!r_ready) begin
            r_shift <= r_hold;
            r_ready <= 1'b1;
            r_line  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= START_BIT;
          end
        end
        START_BIT: begin
          if (w_tc) begin
            r_line  <= r_shift[0];
            r_idx   <= 3'd0;
            r_state <= DATA_BITS;
          end
        end
        DATA_BITS: begin
          if (w_tc) begin
            if (r_idx == 3'd7) begin
              r_line  <= 1'b1;
              r_state <= STOP_BIT;
            end else begin
              r_shift <= r_shift >> 1;
              r_line  <= r_shift[1];
              r_idx   <= r_idx + 3'd1;
            end
          end
        end
        STOP_BIT: begin
          if (w_tc) begin
            r_done <= 1'b1;
            if (!r_ready) begin
              r_shift <= r_hold;
              r_ready <= 1'b1;
              r_line  <= 1'b0;
              r_state <= START_BIT;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_line  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign uart_ready = r_ready;
  assign uart_d_out = r_line;
  assign uart_busy  = r_busy;
  assign uart_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: accepted bytes are queued with their accept edge, and a line monitor
// decodes each frame and checks its exact start cycle, bit timing, busy and done pulse.
module tb_uart_tx;

  localparam int P     = 100000000 / 4000000;
  localparam int FRAME = 10 * P;

  typedef struct {
    logic [7:0] b;
    int         acc;
  } exp_t;

  logic       uart_clock = 1'b0;
  logic       uart_reset = 1'b0;
  logic [7:0] uart_d_in  = 8'h00;
  logic       uart_start = 1'b0;
  logic       uart_ready;
  logic       uart_d_out;
  logic       uart_busy;
  logic       uart_done;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   done_q[$];

  int         fpos = -1;
  int         last_start = -100000;
  exp_t       cur;
  int         bad = 0;
  logic [7:0] rx = 8'h00;

  uart_tx #(
    .baud_rate  (24'd4000000),
    .clock_freq (28'd100000000)
  ) dut (
    .uart_clock (uart_clock),
    .uart_reset (uart_reset),
    .uart_d_in  (uart_d_in),
    .uart_start (uart_start),
    .uart_ready (uart_ready),
    .uart_d_out (uart_d_out),
    .uart_busy  (uart_busy),
    .uart_done  (uart_done)
  );

  always #5 uart_clock = ~uart_clock;
  always @(posedge uart_clock) cyc <= cyc + 1;

  // Monitor: a frame may start no earlier than one edge after accept and no earlier than the end of
  // the previous frame; done must pulse exactly one frame after the start.
  always @(negedge uart_clock) begin
    if (!uart_reset) begin
      fpos = -1;
      last_start = -100000;
    end else begin
      if (done_q.size() != 0 && done_q[0] == cyc) begin
        checks++;
        if (uart_done !== 1'b1) begin
          errors++;
          $display("FAIL done_pulse cyc=%0d got=%b want=1", cyc, uart_done);
        end
        void'(done_q.pop_front());
      end else if (uart_done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL done_spurious cyc=%0d got=%b want=0", cyc, uart_done);
      end

      if (fpos < 0) begin
        if (uart_d_out === 1'b0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_spurious cyc=%0d got=start_bit want=idle", cyc);
            cur.b   = 8'h00;
            cur.acc = cyc;
          end else begin
            int want;
            cur  = exp_q.pop_front();
            want = (cur.acc + 1 > last_start + FRAME) ? cur.acc + 1 : last_start + FRAME;
            if (cyc != want) begin
              errors++;
              $display("FAIL frame_start byte=%h got_cyc=%0d want_cyc=%0d", cur.b, cyc, want);
            end
          end
          last_start = cyc;
          done_q.push_back(cyc + FRAME);
          fpos = 0;
          bad  = 0;
          rx   = 8'h00;
        end else begin
          checks++;
          if (uart_d_out !== 1'b1 || uart_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_line cyc=%0d got line=%b busy=%b want line=1 busy=0",
                     cyc, uart_d_out, uart_busy);
          end
        end
      end

      if (fpos >= 0) begin
        int   bitno;
        logic expbit;
        bitno  = fpos / P;
        expbit = (bitno == 0) ? 1'b0 : (bitno == 9) ? 1'b1 : cur.b[bitno-1];
        if (uart_d_out !== expbit || uart_busy !== 1'b1) bad++;
        if (fpos % P == P / 2 && bitno >= 1 && bitno <= 8) rx[bitno-1] = uart_d_out;
        fpos++;
        if (fpos == FRAME) begin
          checks += 2;
          if (rx !== cur.b) begin
            errors++;
            $display("FAIL frame_byte got=%h want=%h", rx, cur.b);
          end
          if (bad != 0) begin
            errors++;
            $display("FAIL frame_timing byte=%h got=%0d_bad_cycles want=0", cur.b, bad);
          end
          fpos = -1;
        end
      end
    end
  end

  // Called right after a negedge; returns right after the negedge following the accept edge.
  task automatic send(input logic [7:0] b, input bit keep);
    int   t;
    exp_t e;
    t = 0;
    uart_d_in  = b;
    uart_start = 1'b1;
    while (uart_ready !== 1'b1 && t < 4 * FRAME) begin
      @(negedge uart_clock);
      t++;
    end
    checks++;
    if (uart_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout byte=%h got ready=%b want=1", b, uart_ready);
    end else begin
      e.b   = b;
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge uart_clock);
    checks++;
    if (uart_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_accept byte=%h got=%b want=0", b, uart_ready);
    end
    if (!keep) uart_start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || fpos >= 0 || done_q.size() != 0) && t < 20 * FRAME) begin
      @(negedge uart_clock);
      t++;
    end
    checks++;
    if (exp_q.size() != 0 || fpos >= 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got pending=%0d want=0", exp_q.size() + done_q.size());
    end
    repeat (5) @(negedge uart_clock);
  endtask

  initial begin
    uart_start = 1'b1;
    uart_d_in  = 8'hE7;
    repeat (4) @(negedge uart_clock);
    checks++;
    if (uart_d_out !== 1'b1 || uart_ready !== 1'b1 || uart_busy !== 1'b0 || uart_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got line=%b ready=%b busy=%b done=%b want 1 1 0 0",
               uart_d_out, uart_ready, uart_busy, uart_done);
    end
    uart_start = 1'b0;
    uart_reset = 1'b1;
    repeat (30) @(negedge uart_clock);

    send(8'hA5, 1'b0);
    wait_idle();

    send(8'h00, 1'b1);
    send(8'hFF, 1'b0);
    wait_idle();

    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b0);
    wait_idle();

    send(8'h3C, 1'b0);
    repeat (1 + 5 * P + 10) @(negedge uart_clock);
    uart_reset = 1'b0;
    exp_q.delete();
    done_q.delete();
    #1;
    checks++;
    if (uart_d_out !== 1'b1 || uart_ready !== 1'b1 || uart_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_midframe got line=%b ready=%b busy=%b want 1 1 0",
               uart_d_out, uart_ready, uart_busy);
    end
    repeat (2) @(negedge uart_clock);
    uart_reset = 1'b1;
    repeat (3) @(negedge uart_clock);
    send(8'h5A, 1'b0);
    wait_idle();

    send(8'h00, 1'b1);
    send(8'h55, 1'b1);
    send(8'hAA, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h80, 1'b0);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      int         gap;
      b   = 8'($urandom);
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 300));
      send(b, gap == 0);
      repeat (gap) @(negedge uart_clock);
    end
    uart_start = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
8N1 UART transmitter, the transmit-side companion to the team's UART receiver, sharing its baud_rate/clock_freq parameterisation. It accepts bytes from fabric logic through a valid/ready handshake and serialises them on uart_d_out: start bit (0), 8 data bits LSB first, stop bit (1). A one-byte holding register allows back-to-back frames with no idle gap. It is used to stream MRAM statistics back to the host over the same serial link.

Parameters:
baud_rate, 24'd4000000, line bit rate in bits/s
clock_freq, 28'd100000000, uart_clock frequency in Hz
(derived localparam pulse_duration = clock_freq / baud_rate, cycles per bit; default 25; must be >= 2)

Ports:
uart_clock  input  1  single clock for all logic, rising edge
uart_reset  input  1  asynchronous, active-low reset
uart_d_in  input  8  byte to transmit, sampled on accept
uart_start  input  1  valid: uart_d_in holds a byte to send
uart_ready  output  1  holding register empty; accept = uart_start & uart_ready at a rising edge
uart_d_out  output  1  serial line, idle high, registered
uart_busy  output  1  high while a frame is on the line (start through stop bit)
uart_done  output  1  one-cycle pulse when a stop bit completes

Behaviour:
- Reset (async, while uart_reset=0): uart_d_out=1, uart_ready=1, uart_busy=0, uart_done=0, holding register empty, state Idle, all counters 0. Reset mid-frame aborts the frame; the line goes high immediately and the partial byte is discarded.
- Holding register: loaded at the accept edge. uart_ready = holding empty (registered), so ready is 0 in the cycle after accept. uart_d_in is don't-care when no accept occurs.
- States (2-bit enum): Idle, Start_Bit, Data_Bits, Stop_Bit.
- Idle: uart_d_out=1. If the holding register is full at an edge, move it into the shift register, clear holding (ready=1 next cycle), drive uart_d_out=0, go to Start_Bit. Latency: accept at edge k, so the line falls at edge k+1.
- Every bit is held exactly pulse_duration cycles. The bit counter counts 0..pulse_duration-1; at terminal count the next bit is presented on the same edge.
- Start_Bit to Data_Bits: present shift[0].
- Data_Bits: shift right after each bit. A 3-bit index runs 0..7; after bit 7 go to Stop_Bit with line=1.
- Stop_Bit terminal edge: uart_done=1 for one cycle. If holding is full, reload it, line=0 and go to Start_Bit (zero idle gap; frame period is exactly 10*pulse_duration cycles). Otherwise go to Idle.
- Accept while busy is legal, and ready rises when the FSM takes the held byte. Accept and take cannot collide, because ready=0 whenever holding is full.
- uart_busy=1 in Start_Bit/Data_Bits/Stop_Bit. It stays 1 across back-to-back frames.
- Counters are 24-bit unsigned, with no wrap beyond pulse_duration-1. Any illegal state returns to Idle with line=1.

Decomposition:
- Shared package uart_pkg holds:
  - tx state enum;
  - start_data_stop_width = 4'd10;
  - pulse_duration / half_pulse_duration as functions of baud_rate and clock_freq, so they are reused by the receiver.
- One natural sub-module, uart_baud_counter: 24-bit counter with clear input and terminal-count output, parameterised by pulse_duration. It is shared with the receiver later.

Test Plan:
1. Reset: hold uart_reset=0 with uart_start=1 -> uart_d_out=1, uart_ready=1, busy=0, done=0; no accept while in reset.
2. Single byte 0xA5, defaults -> line low from edge k+1 for 25 cycles; then 1,0,1,0,0,1,0,1 at 25 cycles each; stop high 25 cycles. uart_done pulses at edge k+251, busy is 0 after.
3. Back-to-back 0x00 then 0xFF (second accepted during the first frame) -> the second start bit begins on the same edge the first stop bit ends. 500 contiguous line cycles, two done pulses 250 cycles apart, busy never drops.
4. Backpressure: assert uart_start with 0x11, 0x22, 0x33 continuously -> 0x22 is accepted only after 0x11 leaves holding, and 0x33 only after 0x22 leaves. The line shows exactly 0x11, 0x22, 0x33 in order with no duplicates.
5. Reset pulse during data bit 4 of 0x3C -> line high immediately, ready=1. A subsequent 0x5A is sent cleanly with a full start bit.
6. Loopback of uart_d_out into the team's uart_rx (same parameters), sending 0x00, 0x55, 0xAA, 0xFF, 0x80 -> receiver outputs the identical bytes with one valid indication per byte.
